// File: rtl/servo_sweep_seq.sv
`default_nettype none
// ============================================================================
// Module   : servo_sweep_seq
// Brief    : Slew-limited servo setpoint sequencer. Walks a 4-entry
//            {position, dwell} table, moving set_pwm by at most STEP per PWM
//            frame toward each entry, dwelling a programmable number of
//            frames, then advancing (looping or one-shot). FRAME_DIV >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module servo_sweep_seq #(
    parameter logic [15:0] FRAME_DIV = 16'd60000,
    parameter logic [15:0] STEP      = 16'h0080,
    parameter logic [15:0] PARK      = 16'h0ae4,
    parameter logic        LOOP      = 1'b1
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        start,
    input  logic        stop,
    input  logic        wr_en,
    input  logic [1:0]  wr_idx,
    input  logic [15:0] wr_pos,
    input  logic [7:0]  wr_dwell,
    output logic [15:0] set_pwm,
    output logic        frame_tick,
    output logic [1:0]  idx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] c_frame_last = FRAME_DIV - 16'd1;
    localparam logic [1:0]  c_last_idx   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLEW  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_frame_cnt;
    logic [15:0] w_frame_cnt_nxt;
    logic        r_tick;

    logic [15:0] r_tab_pos   [0:3];
    logic [7:0]  r_tab_dwell [0:3];

    logic [15:0] r_pwm;
    logic [15:0] w_pwm_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [1:0]  w_idx_inc;
    logic [15:0] r_target;
    logic [15:0] w_target_nxt;
    logic [7:0]  r_dwell_lat;
    logic [7:0]  w_dwell_lat_nxt;
    logic [7:0]  r_dwell_cnt;
    logic [7:0]  w_dwell_cnt_nxt;
    logic        r_done;
    logic        w_done_nxt;

    logic        w_up;
    logic [15:0] w_dist;
    logic        w_frame_go;

    // Frame counter wraps at FRAME_DIV-1; the tick flag is registered so it is
    // exactly aligned with the counter sitting at its last value.
    assign w_frame_cnt_nxt = (r_frame_cnt == c_frame_last) ? 16'd0 : (r_frame_cnt + 16'd1);

    // Free-running frame counter and tick, active in every state.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_frame_cnt <= 16'd0;
            r_tick      <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
            r_tick      <= (w_frame_cnt_nxt == c_frame_last);
        end
    end

    // Table storage; writes are accepted in any state. The FSM copies an entry
    // when it loads it, so rewriting the active entry only matters next load.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            for (int i = 0; i < 4; i++) begin
                r_tab_pos[i]   <= PARK;
                r_tab_dwell[i] <= 8'd0;
            end
        end else if (wr_en) begin
            r_tab_pos[wr_idx]   <= wr_pos;
            r_tab_dwell[wr_idx] <= wr_dwell;
        end
    end

    // Unsigned distance to target without wrap-around, and slew direction.
    assign w_up       = (r_target > r_pwm);
    assign w_dist     = w_up ? (r_target - r_pwm) : (r_pwm - r_target);
    assign w_idx_inc  = r_idx + 2'd1;
    // A start request coincident with the tick swallows that frame's update.
    assign w_frame_go = r_tick && !start;

    // State register.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decisions for the sweep sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_pwm_nxt       = r_pwm;
        w_idx_nxt       = r_idx;
        w_target_nxt    = r_target;
        w_dwell_lat_nxt = r_dwell_lat;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_done_nxt      = 1'b0;

        if (stop) begin
            // Abort: park in IDLE, keep the servo where it is, no done pulse.
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_idx_nxt       = 2'd0;
                        w_target_nxt    = r_tab_pos[0];
                        w_dwell_lat_nxt = r_tab_dwell[0];
                        w_state_nxt     = ST_SLEW;
                    end
                end

                ST_SLEW: begin
                    if (w_frame_go) begin
                        if (w_dist <= STEP) begin
                            w_pwm_nxt       = r_target;
                            w_dwell_cnt_nxt = r_dwell_lat;
                            w_state_nxt     = ST_DWELL;
                        end else if (w_up) begin
                            w_pwm_nxt = r_pwm + STEP;
                        end else begin
                            w_pwm_nxt = r_pwm - STEP;
                        end
                    end
                end

                ST_DWELL: begin
                    if (w_frame_go) begin
                        if (r_dwell_cnt != 8'd0) begin
                            w_dwell_cnt_nxt = r_dwell_cnt - 8'd1;
                        end else if (r_idx != c_last_idx) begin
                            w_idx_nxt       = w_idx_inc;
                            w_target_nxt    = r_tab_pos[w_idx_inc];
                            w_dwell_lat_nxt = r_tab_dwell[w_idx_inc];
                            w_state_nxt     = ST_SLEW;
                        end else if (LOOP) begin
                            w_idx_nxt       = 2'd0;
                            w_target_nxt    = r_tab_pos[0];
                            w_dwell_lat_nxt = r_tab_dwell[0];
                            w_state_nxt     = ST_SLEW;
                        end else begin
                            // One-shot run complete: hold set_pwm, report done.
                            w_idx_nxt   = 2'd0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Datapath registers: setpoint, active entry, latched entry, dwell count.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_pwm       <= PARK;
            r_idx       <= 2'd0;
            r_target    <= PARK;
            r_dwell_lat <= 8'd0;
            r_dwell_cnt <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_pwm       <= w_pwm_nxt;
            r_idx       <= w_idx_nxt;
            r_target    <= w_target_nxt;
            r_dwell_lat <= w_dwell_lat_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign set_pwm    = r_pwm;
    assign frame_tick = r_tick;
    assign idx        = r_idx;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_servo_sweep_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_sweep_seq
// Brief    : Self-checking bench for servo_sweep_seq. Two instances share all
//            inputs (LOOP=1 and LOOP=0); each is compared every cycle against
//            a frame-level reference model, plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_sweep_seq;

    localparam int FD     = 4;
    localparam int STEP_V = 'h0100;
    localparam int PARK_V = 'h0ae4;

    logic        clk;
    logic        resetb;
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [15:0] wr_pos;
    logic [7:0]  wr_dwell;

    logic [15:0] pwm_l, pwm_o;
    logic        tick_l, tick_o;
    logic [1:0]  idx_l, idx_o;
    logic        busy_l, busy_o;
    logic        done_l, done_o;

    int tests;
    int fails;

    servo_sweep_seq #(
        .FRAME_DIV (16'd4),
        .STEP      (16'h0100),
        .PARK      (16'h0ae4),
        .LOOP      (1'b1)
    ) u_dut_loop (
        .clk        (clk),
        .resetb     (resetb),
        .start      (start),
        .stop       (stop),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_pos     (wr_pos),
        .wr_dwell   (wr_dwell),
        .set_pwm    (pwm_l),
        .frame_tick (tick_l),
        .idx        (idx_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    servo_sweep_seq #(
        .FRAME_DIV (16'd4),
        .STEP      (16'h0100),
        .PARK      (16'h0ae4),
        .LOOP      (1'b0)
    ) u_dut_once (
        .clk        (clk),
        .resetb     (resetb),
        .start      (start),
        .stop       (stop),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_pos     (wr_pos),
        .wr_dwell   (wr_dwell),
        .set_pwm    (pwm_o),
        .frame_tick (tick_o),
        .idx        (idx_o),
        .busy       (busy_o),
        .done       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instance 0 loops, 1 runs once) -------
    int m_cyc;
    int m_mode [2];   // 0 idle, 1 moving toward target, 2 holding
    int m_pwm  [2];
    int m_idx  [2];
    int m_tgt  [2];
    int m_dlat [2];
    int m_dcnt [2];
    int m_done [2];
    int t_pos  [4];
    int t_dw   [4];

    task automatic model_reset();
        m_cyc = 0;
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0; m_pwm[m] = PARK_V; m_idx[m] = 0; m_tgt[m] = PARK_V;
            m_dlat[m] = 0; m_dcnt[m] = 0; m_done[m] = 0;
        end
        for (int e = 0; e < 4; e++) begin
            t_pos[e] = PARK_V; t_dw[e] = 0;
        end
    endtask

    task automatic model_load(input int m, input int e);
        m_idx[m]  = e;
        m_tgt[m]  = t_pos[e];
        m_dlat[m] = t_dw[e];
        m_mode[m] = 1;
    endtask

    function automatic int mtick();
        return ((m_cyc % FD) == FD - 1) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int ft;
        int d;
        ft = mtick();
        for (int m = 0; m < 2; m++) begin
            m_done[m] = 0;
            if (stop) begin
                m_mode[m] = 0;
                m_idx[m]  = 0;
            end else if (m_mode[m] == 0) begin
                if (start) model_load(m, 0);
            end else if (ft != 0 && !start) begin
                if (m_mode[m] == 1) begin
                    d = m_tgt[m] - m_pwm[m];
                    if (d <= STEP_V && d >= -STEP_V) begin
                        m_pwm[m]  = m_tgt[m];
                        m_dcnt[m] = m_dlat[m];
                        m_mode[m] = 2;
                    end else begin
                        m_pwm[m] = m_pwm[m] + ((d > 0) ? STEP_V : -STEP_V);
                    end
                end else begin
                    if (m_dcnt[m] > 0) m_dcnt[m] = m_dcnt[m] - 1;
                    else if (m_idx[m] < 3) model_load(m, m_idx[m] + 1);
                    else if (m == 0) model_load(m, 0);
                    else begin
                        m_mode[m] = 0;
                        m_idx[m]  = 0;
                        m_done[m] = 1;
                    end
                end
            end
        end
        if (wr_en) begin
            t_pos[int'(wr_idx)] = int'(wr_pos);
            t_dw[int'(wr_idx)]  = int'(wr_dwell);
        end
        m_cyc = m_cyc + 1;
    endtask

    // ---------------- checking helpers --------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("loop_pwm",  int'(pwm_l),  m_pwm[0]);
        chk("loop_idx",  int'(idx_l),  m_idx[0]);
        chk("loop_busy", int'(busy_l), (m_mode[0] != 0) ? 1 : 0);
        chk("loop_done", int'(done_l), m_done[0]);
        chk("loop_tick", int'(tick_l), mtick());
        chk("once_pwm",  int'(pwm_o),  m_pwm[1]);
        chk("once_idx",  int'(idx_o),  m_idx[1]);
        chk("once_busy", int'(busy_o), (m_mode[1] != 0) ? 1 : 0);
        chk("once_done", int'(done_o), m_done[1]);
        chk("once_tick", int'(tick_o), mtick());
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (resetb) model_reset();
        else        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Advance until just after the next frame tick edge.
    task automatic next_frame();
        int was;
        int k;
        k = 0;
        do begin
            was = mtick();
            cyc();
            k = k + 1;
        end while (was == 0 && k < 2 * FD);
        if (was == 0) chk("frame_wait_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pwm_l"},  int'(pwm_l),  PARK_V);
        chk({tag, "_busy_l"}, int'(busy_l), 0);
        chk({tag, "_idx_l"},  int'(idx_l),  0);
        chk({tag, "_done_l"}, int'(done_l), 0);
        chk({tag, "_tick_l"}, int'(tick_l), 0);
        chk({tag, "_pwm_o"},  int'(pwm_o),  PARK_V);
        chk({tag, "_busy_o"}, int'(busy_o), 0);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    typedef struct {
        int st;  int sp;  int wr;  int widx; int wpos; int wdw;
        int n;   int epwm; int eidx; int ebusy; int etick;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int found;
        int seen;
        tests = 0;
        fails = 0;

        // {start, stop, wr, widx, wpos, wdw, cycles, pwm, idx, busy, tick}
        vecs[0] = '{0, 0, 1, 0, 'h0ee4, 0, 1, 'h0ae4, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0,      0, 1, 'h0ae4, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0,      0, 1, 'h0ae4, 0, 1, 1};
        vecs[3] = '{0, 0, 0, 0, 0,      0, 1, 'h0be4, 0, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 0,      0, 4, 'h0ce4, 0, 1, 0};
        vecs[5] = '{0, 0, 0, 0, 0,      0, 4, 'h0de4, 0, 1, 0};
        vecs[6] = '{0, 0, 0, 0, 0,      0, 4, 'h0ee4, 0, 1, 0};
        vecs[7] = '{0, 0, 0, 0, 0,      0, 4, 'h0ee4, 1, 1, 0};

        resetb = 1'b1; wr_idx = 2'd0; wr_pos = 16'd0; wr_dwell = 8'd0;
        idle_inputs();
        model_reset();
        repeat (3) cyc();
        chk_reset_vals("reset_hold");
        resetb = 1'b0;

        // Reset release, tick cadence and a four-frame slew up to 0x0ee4.
        for (int i = 0; i < 8; i++) begin
            start    = (vecs[i].st != 0);
            stop     = (vecs[i].sp != 0);
            wr_en    = (vecs[i].wr != 0);
            wr_idx   = 2'(vecs[i].widx);
            wr_pos   = 16'(vecs[i].wpos);
            wr_dwell = 8'(vecs[i].wdw);
            cyc();
            idle_inputs();
            for (int k = 1; k < vecs[i].n; k++) cyc();
            chk($sformatf("vec%0d_pwm", i),  int'(pwm_l),  vecs[i].epwm);
            chk($sformatf("vec%0d_idx", i),  int'(idx_l),  vecs[i].eidx);
            chk($sformatf("vec%0d_busy", i), int'(busy_l), vecs[i].ebusy);
            chk($sformatf("vec%0d_tick", i), int'(tick_l), vecs[i].etick);
        end

        // Stop together with start on a tick cycle while slewing down.
        for (int k = 0; k < FD && mtick() == 0; k++) cyc();
        start = 1'b1; stop = 1'b1;
        cyc();
        idle_inputs();
        chk("stopstart_busy", int'(busy_l), 0);
        chk("stopstart_idx",  int'(idx_l),  0);
        chk("stopstart_pwm",  int'(pwm_l),  'h0ee4);
        chk("stopstart_done", int'(done_l), 0);
        cyc();
        chk("stopstart_done2", int'(done_l), 0);
        chk("stopstart_pwm2",  int'(pwm_l),  'h0ee4);

        resetb = 1'b1;
        model_reset();
        repeat (2) cyc();
        resetb = 1'b0;

        // Small step plus dwell of 2 frames.
        wr_en = 1'b1; wr_idx = 2'd0; wr_pos = 16'h0b00; wr_dwell = 8'd2;
        cyc();
        wr_idx = 2'd1; wr_pos = 16'h0b00; wr_dwell = 8'd50;
        cyc();
        wr_en = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        next_frame();
        chk("small_pwm",  int'(pwm_l), 'h0b00);
        chk("small_idx",  int'(idx_l), 0);
        next_frame();
        next_frame();
        chk("dwell_idx_hold", int'(idx_l),  0);
        chk("dwell_busy",     int'(busy_l), 1);
        next_frame();
        chk("dwell_idx_adv",  int'(idx_l),  1);

        // Asynchronous reset in the middle of a long dwell.
        next_frame();
        cyc();
        chk("pre_reset_busy", int'(busy_l), 1);
        #1 resetb = 1'b1;
        model_reset();
        #1 chk_reset_vals("async_reset");
        repeat (2) cyc();
        resetb = 1'b0;
        repeat (10) cyc();
        chk_reset_vals("post_reset_idle");

        // One-shot run over a table of parked, zero-dwell entries.
        start = 1'b1;
        cyc();
        start = 1'b0;
        found = 0;
        seen  = 0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            cyc();
            seen = seen | (1 << int'(idx_o));
            if (done_o) found = 1;
        end
        chk("once_done_seen", found, 1);
        chk("once_idx_span",  seen, 'hf);
        chk("once_busy_end",  int'(busy_o), 0);
        chk("once_pwm_end",   int'(pwm_o), PARK_V);
        chk("loop_still_run", int'(busy_l), 1);
        cyc();
        chk("once_done_width", int'(done_o), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_idx   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       wr_pos = 16'h0000;
                1:       wr_pos = 16'hffff;
                default: wr_pos = 16'($urandom_range('h0900, 'h0d00));
            endcase
            wr_dwell = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                resetb = 1'b1;
                model_reset();
            end else begin
                resetb = 1'b0;
            end
            cyc();
        end
        idle_inputs();
        resetb = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servo_sweep_seq.md
SERVO_SWEEP_SEQ -- requirements
Module: servo_sweep_seq

Interface
REQ-001 SHALL provide parameter FRAME_DIV, default 16'd60000, meaning clk cycles per PWM frame (one setpoint update slot).
REQ-002 SHALL provide parameter STEP, default 16'h0080, meaning maximum set_pwm change per frame (slew limit).
REQ-003 SHALL provide parameter PARK, default 16'h0ae4, meaning the reset and idle setpoint.
REQ-004 SHALL provide parameter LOOP, default 1'b1, meaning 1 = repeat the table forever, 0 = run the table once.
REQ-005 SHALL provide port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL provide port resetb, input, 1, asynchronous active-high reset (1 = reset asserted).
REQ-007 SHALL provide port start, input, 1, single-cycle request to begin the sequence.
REQ-008 SHALL provide port stop, input, 1, single-cycle request to abort the sequence.
REQ-009 SHALL provide port wr_en, input, 1, table write strobe.
REQ-010 SHALL provide port wr_idx, input, 2, table entry to write.
REQ-011 SHALL provide port wr_pos, input, 16, target setpoint for the entry.
REQ-012 SHALL provide port wr_dwell, input, 8, dwell in frames for the entry.
REQ-013 SHALL provide port set_pwm, output, 16, setpoint driven to the servo PWM generator.
REQ-014 SHALL provide port frame_tick, output, 1, one-cycle pulse per frame.
REQ-015 SHALL provide port idx, output, 2, active table entry.
REQ-016 SHALL provide port busy, output, 1, high while in SLEW or DWELL.
REQ-017 SHALL provide port done, output, 1, one-cycle pulse when a LOOP=0 run completes.

Function
REQ-018 SHALL run a free-running frame counter 0..FRAME_DIV-1 in all states; frame_tick is high exactly in the cycle the counter equals FRAME_DIV-1.
REQ-019 SHALL hold a 4-entry table {pos, dwell}; wr_en writes the entry at the next edge in any state; a write to the active entry takes effect only on that entry's next load.
REQ-020 SHALL implement FSM states IDLE, SLEW, DWELL.
REQ-021 SHALL, in IDLE on start, set idx=0, latch target=table[0].pos, and enter SLEW at the next edge; start in SLEW/DWELL is ignored.
REQ-022 SHALL, in SLEW on frame_tick, set set_pwm=target and enter DWELL with dwell counter=table[idx].dwell when |target-set_pwm| <= STEP; otherwise move set_pwm by exactly STEP toward target using unsigned compare with no wrap-around.
REQ-023 SHALL, in DWELL on frame_tick, decrement the dwell counter when it is nonzero; when it is zero, advance to the next entry (dwell 0 = leave on the first tick).
REQ-024 SHALL advance idx by 1 and load the new target into SLEW; at idx=3, wrap to 0 and re-enter SLEW when LOOP=1, or go to IDLE, pulse done for one cycle, and hold set_pwm when LOOP=0.
REQ-025 SHALL update set_pwm only at frame_tick edges; the new value is visible the cycle after frame_tick.
REQ-026 SHALL, on stop in any state, enter IDLE at the next edge with idx=0, set_pwm holding its current value, and no done pulse; stop wins over a simultaneous start.
REQ-027 SHALL have stop or start coincident with frame_tick suppress that tick's set_pwm update.

Reset
REQ-028 SHALL, while resetb=1, asynchronously force: state IDLE, frame counter 0, frame_tick 0, set_pwm=PARK, idx 0, busy 0, done 0, dwell counter 0, all table entries {PARK, 0}.
REQ-029 SHALL abandon a sequence in progress when reset is asserted mid-operation; after release the block stays in IDLE until start.

Verification (FRAME_DIV=4, STEP=16'h0100, PARK=16'h0ae4)
REQ-030 SHALL cover reset release: frame_tick every 4th cycle, set_pwm=16'h0ae4, busy=0.
REQ-031 SHALL cover a slew: entry0={16'h0ee4,0}, start -> set_pwm 0be4, 0ce4, 0de4, 0ee4 on successive ticks, then idx=1.
REQ-032 SHALL cover a small step and dwell: entry pos=16'h0b00, dwell=2 from 0ae4 -> one tick to 0b00, then 3 further ticks in DWELL before idx advances.
REQ-033 SHALL cover LOOP=0: all dwell=0, pos=PARK -> idx 0..3, then a done pulse, busy=0, state IDLE.
REQ-034 SHALL cover stop/start together mid-SLEW -> IDLE next cycle, set_pwm frozen, idx=0, no done.
REQ-035 SHALL cover reset asserted during DWELL -> all outputs immediately at reset values without waiting for clk.
